data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
// Two-requester round-robin arbiter in front of a 64x8 byte memory. Each
// granted request moves one 32-bit word as four big-endian byte beats, or
// completes at once with an error when the address is outside 0..63.
//
// Ports
//   clk_i            : clock, all state changes on the rising edge
//   reset_n_i        : asynchronous active-low reset
//   req_a_i/req_b_i  : requests, held high until the matching ack
//   wr_a_i/wr_b_i    : 1 = word write, 0 = word read
//   addr_a_i/addr_b_i: byte address of the word's MSB
//   wdata_a_i/_b_i   : write word
//   ack_a_o/ack_b_o  : one-cycle completion pulse
//   err_a_o/err_b_o  : out-of-range flag, valid with ack
//   rdata_o          : read word, valid in the ack cycle of a read
//   mem_addr_o       : byte address to the memory
//   mem_wdata_o      : byte to write
//   mem_we_o         : byte write enable
//   mem_rdata_i      : byte read, combinational from mem_addr_o
// ---------------------------------------------------------------------------
module data_mem_arbiter (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        req_a_i,
   input  logic        req_b_i,
   input  logic        wr_a_i,
   input  logic        wr_b_i,
   input  logic [31:0] addr_a_i,
   input  logic [31:0] addr_b_i,
   input  logic [31:0] wdata_a_i,
   input  logic [31:0] wdata_b_i,
   output logic        ack_a_o,
   output logic        ack_b_o,
   output logic        err_a_o,
   output logic        err_b_o,
   output logic [31:0] rdata_o,
   output logic [5:0]  mem_addr_o,
   output logic [7:0]  mem_wdata_o,
   output logic        mem_we_o,
   input  logic [7:0]  mem_rdata_i
);

   typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

   state_t      state_q;
   logic [1:0]  beat_q;
   logic        last_b_q;     // 1 = B was granted last
   logic        wr_q;
   logic [5:0]  addr_q;
   logic [31:0] wdata_q;
   logic        ack_a_q, ack_b_q, err_a_q, err_b_q;
   logic [31:0] rdata_q;
   logic [5:0]  mem_addr_q;
   logic [7:0]  mem_wdata_q;
   logic        mem_we_q;

   // Grant decode, only acted on in IDLE
   logic        grant_v_d;
   logic        grant_b_d;
   logic        g_wr_d;
   logic [31:0] g_addr_d;
   logic [31:0] g_wdata_d;
   logic        g_err_d;
   logic [1:0]  next_beat_d;

   // Big-endian: beat 0 carries bits 31:24
   function automatic logic [7:0] beat_byte(input logic [31:0] w, input logic [1:0] k);
      logic [7:0] b;
      case (k)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      return b;
   endfunction

   always_comb begin
      grant_v_d   = req_a_i | req_b_i;
      // On a tie B wins only when A was granted last
      grant_b_d   = req_b_i & (~req_a_i | ~last_b_q);
      g_wr_d      = grant_b_d ? wr_b_i    : wr_a_i;
      g_addr_d    = grant_b_d ? addr_b_i  : addr_a_i;
      g_wdata_d   = grant_b_d ? wdata_b_i : wdata_a_i;
      g_err_d     = |g_addr_d[31:6];
      next_beat_d = beat_q + 2'd1;
   end

   // Memory-side outputs are registered one edge ahead so they are valid
   // for the whole beat cycle they belong to.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= IDLE;
         beat_q      <= 2'd0;
         last_b_q    <= 1'b1;
         wr_q        <= 1'b0;
         addr_q      <= 6'd0;
         wdata_q     <= 32'd0;
         ack_a_q     <= 1'b0;
         ack_b_q     <= 1'b0;
         err_a_q     <= 1'b0;
         err_b_q     <= 1'b0;
         rdata_q     <= 32'd0;
         mem_addr_q  <= 6'd0;
         mem_wdata_q <= 8'd0;
         mem_we_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_v_d) begin
                  last_b_q <= grant_b_d;
                  wr_q     <= g_wr_d;
                  addr_q   <= g_addr_d[5:0];
                  wdata_q  <= g_wdata_d;
                  beat_q   <= 2'd0;
                  if (g_err_d) begin
                     state_q <= DONE;
                     ack_a_q <= ~grant_b_d;
                     ack_b_q <= grant_b_d;
                     err_a_q <= ~grant_b_d;
                     err_b_q <= grant_b_d;
                  end else begin
                     state_q     <= BEAT;
                     mem_addr_q  <= g_addr_d[5:0];
                     mem_wdata_q <= g_wr_d ? g_wdata_d[31:24] : 8'd0;
                     mem_we_q    <= g_wr_d;
                  end
               end
            end
            BEAT: begin
               if (!wr_q) begin
                  case (beat_q)
                     2'd0:    rdata_q[31:24] <= mem_rdata_i;
                     2'd1:    rdata_q[23:16] <= mem_rdata_i;
                     2'd2:    rdata_q[15:8]  <= mem_rdata_i;
                     default: rdata_q[7:0]   <= mem_rdata_i;
                  endcase
               end
               if (beat_q == 2'd3) begin
                  state_q     <= DONE;
                  mem_addr_q  <= 6'd0;
                  mem_wdata_q <= 8'd0;
                  mem_we_q    <= 1'b0;
                  ack_a_q     <= ~last_b_q;
                  ack_b_q     <= last_b_q;
               end else begin
                  beat_q      <= next_beat_d;
                  // 6-bit add wraps 63 -> 0
                  mem_addr_q  <= addr_q + {4'd0, next_beat_d};
                  mem_wdata_q <= wr_q ? beat_byte(wdata_q, next_beat_d) : 8'd0;
               end
            end
            DONE: begin
               state_q <= IDLE;
               beat_q  <= 2'd0;
               ack_a_q <= 1'b0;
               ack_b_q <= 1'b0;
               err_a_q <= 1'b0;
               err_b_q <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ack_a_o     = ack_a_q;
   assign ack_b_o     = ack_b_q;
   assign err_a_o     = err_a_q;
   assign err_b_o     = err_b_q;
   assign rdata_o     = rdata_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_we_o    = mem_we_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_mem_arbiter
// Bench for data_mem_arbiter with a behavioural 64x8 memory. Expected acks
// and expected memory writes are queued when a request is driven and popped
// when the DUT produces them.
// ---------------------------------------------------------------------------
module tb_data_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_a, req_b, wr_a, wr_b;
   logic [31:0] addr_a, addr_b, wdata_a, wdata_b;
   logic        ack_a, ack_b, err_a, err_b;
   logic [31:0] rdata;
   logic [5:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic [7:0]  mem_rdata;

   always #5 clk = ~clk;

   data_mem_arbiter dut (
      .clk_i       (clk),
      .reset_n_i   (rst_n),
      .req_a_i     (req_a),
      .req_b_i     (req_b),
      .wr_a_i      (wr_a),
      .wr_b_i      (wr_b),
      .addr_a_i    (addr_a),
      .addr_b_i    (addr_b),
      .wdata_a_i   (wdata_a),
      .wdata_b_i   (wdata_b),
      .ack_a_o     (ack_a),
      .ack_b_o     (ack_b),
      .err_a_o     (err_a),
      .err_b_o     (err_b),
      .rdata_o     (rdata),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_we_o    (mem_we),
      .mem_rdata_i (mem_rdata)
   );

   // Physical memory driven by the DUT
   logic [7:0] phys [64];
   logic       init_mem;
   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < 64; i++) phys[i] <= 8'(i);
      end else if (mem_we) begin
         phys[mem_addr] <= mem_wdata;
      end
   end
   assign mem_rdata = phys[mem_addr];

   // Reference model
   logic [7:0]  model [64];
   logic [31:0] last_rd;

   typedef struct {
      bit          is_b;
      bit          err;
      logic [31:0] rd;
      int          issue;
      int          lat;
   } txn_t;
   typedef struct {
      logic [5:0] a;
      logic [7:0] d;
   } wr_t;

   txn_t txq[$];
   wr_t  wq[$];

   int  cyc = 0;
   int  total = 0;
   int  bad = 0;
   bit  tie_mode = 1'b0;
   int  tie_acks = 0;
   int  last_ack = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   // Monitor: writes and acks compared against the scoreboard queues
   txn_t mt;
   wr_t  mw;
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (mem_we) begin
            if (wq.size() == 0) chk("we_unexp", 32'd1, 32'd0);
            else begin
               mw = wq.pop_front();
               chk("we_addr", {26'd0, mem_addr}, {26'd0, mw.a});
               chk("we_data", {24'd0, mem_wdata}, {24'd0, mw.d});
               $display("cyc %0d write byte [%0d]=%h", cyc, mem_addr, mem_wdata);
            end
         end
         if (ack_a || ack_b) begin
            chk("one_ack", {31'd0, ack_a & ack_b}, 32'd0);
            if (txq.size() == 0) chk("ack_unexp", 32'd1, 32'd0);
            else begin
               mt = txq.pop_front();
               chk("ack_who", {31'd0, ack_b}, {31'd0, mt.is_b});
               chk("err", {31'd0, mt.is_b ? err_b : err_a}, {31'd0, mt.err});
               chk("rdata", rdata, mt.rd);
               chk("idle_bus", {18'd0, mem_addr, mem_wdata}, 32'd0);
               if (mt.lat >= 0) chk("latency", 32'(cyc - mt.issue), 32'(mt.lat));
               if (tie_mode && tie_acks > 0) chk("ack_gap", 32'(cyc - last_ack), 32'd6);
               $display("cyc %0d ack %s err=%0b rdata=%h", cyc, ack_b ? "B" : "A",
                        ack_b ? err_b : err_a, rdata);
            end
            last_ack = cyc;
            tie_acks++;
         end
      end
   end

   // Queue the expected outcome of one request and update the model
   task automatic expect_txn(input bit is_b, input bit wr, input logic [31:0] addr,
                             input logic [31:0] data, input int lat);
      bit   err;
      txn_t t;
      wr_t  w;
      logic [5:0] a;
      err = |addr[31:6];
      if (!err) begin
         for (int k = 0; k < 4; k++) begin
            a = addr[5:0] + 6'(k);
            if (wr) begin
               w.a = a;
               w.d = data[31 - 8*k -: 8];
               wq.push_back(w);
               model[a] = w.d;
            end else begin
               last_rd[31 - 8*k -: 8] = model[a];
            end
         end
      end
      t.is_b  = is_b;
      t.err   = err;
      t.rd    = last_rd;
      t.issue = cyc;
      t.lat   = lat;
      txq.push_back(t);
   endtask

   task automatic do_req(input bit is_b, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data);
      bit seen;
      @(negedge clk);
      expect_txn(is_b, wr, addr, data, (|addr[31:6]) ? 1 : 5);
      if (is_b) begin req_b = 1'b1; wr_b = wr; addr_b = addr; wdata_b = data; end
      else      begin req_a = 1'b1; wr_a = wr; addr_a = addr; wdata_a = data; end
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (i == 0) begin
            // Inputs must be ignored once granted
            if (is_b) begin wr_b = ~wr; addr_b = $urandom; wdata_b = $urandom; end
            else      begin wr_a = ~wr; addr_a = $urandom; wdata_a = $urandom; end
         end
         if (is_b ? ack_b : ack_a) seen = 1'b1;
      end
      req_a = 1'b0;
      req_b = 1'b0;
      chk("ack_seen", {31'd0, seen}, 32'd1);
   endtask

   int n_ack;

   initial begin
      rst_n = 1'b0; init_mem = 1'b1;
      req_a = 0; req_b = 0; wr_a = 0; wr_b = 0;
      addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0;
      last_rd = 32'd0;
      for (int i = 0; i < 64; i++) model[i] = 8'(i);
      repeat (2) @(negedge clk);
      init_mem = 1'b0;
      chk("rst_ctl", {28'd0, ack_a, ack_b, err_a, err_b}, 32'd0);
      chk("rst_bus", {17'd0, mem_we, mem_addr, mem_wdata}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      rst_n = 1'b1;

      // Directed traffic
      do_req(1'b0, 1'b1, 32'd8,  32'h11223344);
      do_req(1'b1, 1'b0, 32'd8,  32'h0);
      do_req(1'b0, 1'b1, 32'd62, 32'hAABBCCDD);
      do_req(1'b1, 1'b0, 32'd62, 32'h0);
      do_req(1'b0, 1'b1, 32'd64, 32'hDEADBEEF);
      do_req(1'b1, 1'b0, 32'h1000_0000, 32'h0);
      do_req(1'b0, 1'b0, 32'd62, 32'h0);

      // Tie from reset: order A, B, A with acks 6 cycles apart
      @(negedge clk);
      rst_n = 1'b0;
      last_rd = 32'd0;
      expect_txn(1'b0, 1'b0, 32'd8, 32'd0, -1);
      expect_txn(1'b1, 1'b0, 32'd8, 32'd0, -1);
      expect_txn(1'b0, 1'b0, 32'd8, 32'd0, -1);
      req_a = 1'b1; req_b = 1'b1; wr_a = 0; wr_b = 0; addr_a = 8; addr_b = 8;
      tie_mode = 1'b1; tie_acks = 0;
      @(negedge clk);
      rst_n = 1'b1;
      n_ack = 0;
      for (int i = 0; i < 40 && n_ack < 3; i++) begin
         @(negedge clk);
         if (ack_a || ack_b) n_ack++;
      end
      req_a = 1'b0; req_b = 1'b0;
      chk("tie_acks", 32'(n_ack), 32'd3);
      tie_mode = 1'b0;

      // Reset during beat 2 of a write to address 0: bytes 0,1 only
      @(negedge clk);
      begin
         wr_t w;
         w.a = 6'd0; w.d = 8'h55; wq.push_back(w); model[0] = 8'h55;
         w.a = 6'd1; w.d = 8'h66; wq.push_back(w); model[1] = 8'h66;
      end
      req_a = 1'b1; wr_a = 1'b1; addr_a = 0; wdata_a = 32'h55667788;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      req_a = 1'b0;
      last_rd = 32'd0;
      #1;
      chk("mid_rst_ctl", {28'd0, ack_a, ack_b, err_a, err_b}, 32'd0);
      chk("mid_rst_bus", {17'd0, mem_we, mem_addr, mem_wdata}, 32'd0);
      chk("mid_rst_rdata", rdata, 32'd0);
      chk("mid_rst_wq", 32'(wq.size()), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      do_req(1'b0, 1'b0, 32'd0, 32'h0);

      // Random mix, including out-of-range addresses
      for (int i = 0; i < 8; i++) begin
         do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 70)), $urandom);
      end

      repeat (3) @(negedge clk);
      for (int i = 0; i < 64; i++) chk("mem_byte", {24'd0, phys[i]}, {24'd0, model[i]});
      chk("txq_empty", 32'(txq.size()), 32'd0);
      chk("wq_empty", 32'(wq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
